// File: rtl/fir_xifu_result_fifo_if.sv
// Result channel bundle between the FIR XIFU writeback stage, the result buffer and the core.
// The writeback/core side uses master; the buffer uses slave.
interface fir_xifu_result_fifo_if #(
    parameter int DEPTH  = 4,
    parameter int ID_W   = 4,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid_i;
    logic              in_ready_o;
    logic [ID_W-1:0]   in_id_i;
    logic [DATA_W-1:0] in_data_i;
    logic [4:0]        in_rd_i;
    logic              in_we_i;
    logic              in_err_i;

    logic              out_valid_o;
    logic              out_ready_i;
    logic [ID_W-1:0]   out_id_o;
    logic [DATA_W-1:0] out_data_o;
    logic [4:0]        out_rd_o;
    logic              out_we_o;
    logic              out_err_o;

    logic [CNT_W-1:0]  count_o;
    logic              full_o;
    logic              empty_o;

    modport master (
        output in_valid_i, in_id_i, in_data_i, in_rd_i, in_we_i, in_err_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_id_o, out_data_o, out_rd_o, out_we_o, out_err_o,
        input  count_o, full_o, empty_o
    );

    modport slave (
        input  in_valid_i, in_id_i, in_data_i, in_rd_i, in_we_i, in_err_i, out_ready_i,
        output in_ready_o, out_valid_o, out_id_o, out_data_o, out_rd_o, out_we_o, out_err_o,
        output count_o, full_o, empty_o
    );
endinterface

// File: rtl/fir_xifu_result_fifo.sv
// In-order result buffer between FIR XIFU writeback and the core XIF result channel.
// Outputs are driven purely from state, so core backpressure never reaches writeback combinationally.
module fir_xifu_result_fifo #(
    parameter int DEPTH  = 4,
    parameter int ID_W   = 4,
    parameter int DATA_W = 32
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    fir_xifu_result_fifo_if.slave rif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [4:0]        rd;
        logic              we;
        logic              err;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign push  = rif.in_valid_i & ~full;
    assign pop   = ~empty & rif.out_ready_i;

    // Control state: pointers and occupancy; clear outranks any handshake in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is left unreset; the empty mask below keeps stale entries off the outputs.
    always_ff @(posedge clk_i) begin
        if (push && !clear_i) begin
            mem[wr_ptr] <= '{id:   rif.in_id_i,
                             data: rif.in_data_i,
                             rd:   rif.in_rd_i,
                             we:   rif.in_we_i,
                             err:  rif.in_err_i};
        end
    end

    always_comb begin
        head = '0;
        if (!empty) head = mem[rd_ptr];
    end

    assign rif.in_ready_o  = ~full;
    assign rif.out_valid_o = ~empty;
    assign rif.out_id_o    = head.id;
    assign rif.out_data_o  = head.data;
    assign rif.out_rd_o    = head.rd;
    assign rif.out_we_o    = head.we;
    assign rif.out_err_o   = head.err;
    assign rif.count_o     = count;
    assign rif.full_o      = full;
    assign rif.empty_o     = empty;
endmodule

// File: tb/tb_fir_xifu_result_fifo.sv
// Directed bench for fir_xifu_result_fifo: reset, single result, fill, streaming, backpressure,
// flush and asynchronous reset, with a small in-order queue tracking the expected head and occupancy.
module tb_fir_xifu_result_fifo;
    localparam int DEPTH  = 4;
    localparam int ID_W   = 4;
    localparam int DATA_W = 32;

    logic clk;
    logic rst_n;
    logic clear;
    int   checks;
    int   errors;

    logic [42:0] q[$];

    fir_xifu_result_fifo_if #(.DEPTH(DEPTH), .ID_W(ID_W), .DATA_W(DATA_W)) rif ();

    fir_xifu_result_fifo #(.DEPTH(DEPTH), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (clear),
        .rif     (rif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_in(input logic v, input logic [3:0] id, input logic [31:0] data,
                            input logic [4:0] rd, input logic we, input logic err);
        rif.in_valid_i = v;
        rif.in_id_i    = id;
        rif.in_data_i  = data;
        rif.in_rd_i    = rd;
        rif.in_we_i    = we;
        rif.in_err_i   = err;
    endtask

    // One clock: update the expected queue from the inputs applied, then compare after the edge.
    task automatic cycle(input string tag);
        bit mpush;
        bit mpop;
        logic [42:0] h;
        mpush = rif.in_valid_i && (q.size() < DEPTH);
        mpop  = (q.size() > 0) && rif.out_ready_i;
        @(posedge clk);
        if (clear) begin
            q.delete();
        end else begin
            if (mpop) void'(q.pop_front());
            if (mpush) q.push_back({rif.in_err_i, rif.in_we_i, rif.in_rd_i, rif.in_id_i, rif.in_data_i});
        end
        #1;
        check({tag, "_count"}, 64'(rif.count_o), 64'(q.size()));
        check({tag, "_valid"}, 64'(rif.out_valid_o), 64'(q.size() != 0));
        check({tag, "_ready"}, 64'(rif.in_ready_o), 64'(q.size() < DEPTH));
        check({tag, "_full"}, 64'(rif.full_o), 64'(q.size() == DEPTH));
        check({tag, "_empty"}, 64'(rif.empty_o), 64'(q.size() == 0));
        if (q.size() != 0) begin
            h = q[0];
            check({tag, "_head"},
                  64'({rif.out_err_o, rif.out_we_o, rif.out_rd_o, rif.out_id_o, rif.out_data_o}),
                  64'(h));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clear  = 1'b0;
        rif.out_ready_i = 1'b0;
        drive_in(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 64'(rif.count_o), 64'd0);
        check("rst_empty", 64'(rif.empty_o), 64'd1);
        check("rst_full", 64'(rif.full_o), 64'd0);
        check("rst_valid", 64'(rif.out_valid_o), 64'd0);
        check("rst_ready", 64'(rif.in_ready_o), 64'd1);
        check("rst_fields", 64'({rif.out_err_o, rif.out_we_o, rif.out_rd_o, rif.out_id_o, rif.out_data_o}), 64'd0);
        rst_n = 1'b1;

        // Single result, latency one cycle
        rif.out_ready_i = 1'b1;
        drive_in(1'b1, 4'd3, 32'hDEAD_BEEF, 5'd10, 1'b1, 1'b0);
        cycle("single_push");
        check("single_valid", 64'(rif.out_valid_o), 64'd1);
        check("single_id", 64'(rif.out_id_o), 64'd3);
        check("single_data", 64'(rif.out_data_o), 64'hDEAD_BEEF);
        check("single_rd", 64'(rif.out_rd_o), 64'd10);
        check("single_we", 64'(rif.out_we_o), 64'd1);
        drive_in(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        cycle("single_pop");
        check("single_empty", 64'(rif.empty_o), 64'd1);

        // Fill to full, then a held fifth push
        rif.out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_in(1'b1, 4'(i), 32'h100 + 32'(i), 5'(i + 1), 1'b1, 1'(i == 2));
            cycle("fill");
        end
        check("fill_full", 64'(rif.full_o), 64'd1);
        check("fill_ready", 64'(rif.in_ready_o), 64'd0);
        check("fill_count", 64'(rif.count_o), 64'd4);
        drive_in(1'b1, 4'd4, 32'h104, 5'd5, 1'b0, 1'b0);
        cycle("fill_held");
        check("held_count", 64'(rif.count_o), 64'd4);
        check("held_head", 64'(rif.out_id_o), 64'd0);
        rif.out_ready_i = 1'b1;
        cycle("drain0");
        check("drain_id1", 64'(rif.out_id_o), 64'd1);
        cycle("drain1");
        check("drain_id2", 64'(rif.out_id_o), 64'd2);
        check("drain_cnt_after_id4", 64'(rif.count_o), 64'd3);
        drive_in(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        cycle("drain2");
        check("drain_id3", 64'(rif.out_id_o), 64'd3);
        check("drain_err3", 64'(rif.out_err_o), 64'd0);
        cycle("drain3");
        check("drain_id4", 64'(rif.out_id_o), 64'd4);
        check("drain_data4", 64'(rif.out_data_o), 64'h104);
        cycle("drain4");
        check("drain_empty", 64'(rif.empty_o), 64'd1);

        // Streaming at count 2 with wrapping ids
        rif.out_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_in(1'b1, 4'(i), 32'hA000_0000 + 32'(i), 5'd7, 1'b1, 1'b0);
            cycle("stream_pre");
        end
        rif.out_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_in(1'b1, 4'((i + 2) % 16), 32'hA000_0000 + 32'(i + 2), 5'd7, 1'b1, 1'b0);
            cycle("stream");
            check("stream_cnt2", 64'(rif.count_o), 64'd2);
            check("stream_id", 64'(rif.out_id_o), 64'((i + 1) % 16));
        end

        // Backpressure: head (item 20, id 4) must hold still
        drive_in(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        rif.out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle("bp");
            check("bp_valid", 64'(rif.out_valid_o), 64'd1);
            check("bp_id", 64'(rif.out_id_o), 64'd4);
            check("bp_data", 64'(rif.out_data_o), 64'hA000_0014);
        end

        // Flush at count 3 together with a push and a pop
        drive_in(1'b1, 4'd9, 32'h99, 5'd9, 1'b1, 1'b0);
        cycle("flush_pre");
        check("flush_pre_cnt", 64'(rif.count_o), 64'd3);
        clear = 1'b1;
        rif.out_ready_i = 1'b1;
        drive_in(1'b1, 4'd10, 32'hAA, 5'd1, 1'b1, 1'b0);
        cycle("flush");
        check("flush_count", 64'(rif.count_o), 64'd0);
        check("flush_valid", 64'(rif.out_valid_o), 64'd0);
        check("flush_empty", 64'(rif.empty_o), 64'd1);
        clear = 1'b0;
        rif.out_ready_i = 1'b0;
        drive_in(1'b1, 4'd7, 32'h77, 5'd3, 1'b0, 1'b1);
        cycle("post_flush");
        check("post_flush_id", 64'(rif.out_id_o), 64'd7);
        check("post_flush_err", 64'(rif.out_err_o), 64'd1);

        // Asynchronous reset with two entries held
        drive_in(1'b1, 4'd8, 32'h88, 5'd4, 1'b1, 1'b0);
        cycle("pre_arst");
        drive_in(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        check("pre_arst_cnt", 64'(rif.count_o), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(rif.out_valid_o), 64'd0);
        check("arst_count", 64'(rif.count_o), 64'd0);
        check("arst_empty", 64'(rif.empty_o), 64'd1);
        check("arst_ready", 64'(rif.in_ready_o), 64'd1);
        check("arst_id", 64'(rif.out_id_o), 64'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_in(1'b1, 4'd12, 32'hC0FFEE, 5'd2, 1'b1, 1'b0);
        cycle("after_arst");
        check("after_arst_id", 64'(rif.out_id_o), 64'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
